// File: rtl/gate_sweep_pkg.sv
// Shared types, op codes and reference functions for the gate truth-table sweeper.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam int MAX_N = 8;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_XNOR);
  endfunction

  // Bits at or above n are masked to the identity of each reduction, so a
  // narrow gate can be evaluated through the fixed-width vector.
  function automatic logic ref_eval(input logic [2:0] op,
                                    input logic [MAX_N-1:0] vec,
                                    input int unsigned n);
    logic [MAX_N-1:0] mask;
    logic             r;
    for (int i = 0; i < MAX_N; i++) mask[i] = (i < n);
    case (op)
      OP_AND:  r = &(vec | ~mask);
      OP_OR:   r = |(vec & mask);
      OP_NAND: r = ~&(vec | ~mask);
      OP_NOR:  r = ~|(vec & mask);
      OP_XOR:  r = ^(vec & mask);
      OP_XNOR: r = ~^(vec & mask);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational N-input reference gate; the golden function a sweep compares against.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] vec,
  output logic         y
);

  logic [MAX_N-1:0] vec_ext;

  always_comb begin
    vec_ext        = '0;
    vec_ext[N-1:0] = vec;
    y              = ref_eval(op, vec_ext, N);
  end

endmodule

// File: rtl/gate_sweep_engine.sv
// Truth-table sweeper: drives every N-bit vector into a gate, samples and scores it.
// Optional feature macro: FIRST_FAIL_CAPTURE_EN (records the first failing vector).
module gate_sweep_engine
  import gate_sweep_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  output logic [N-1:0] gate_in,
  input  logic         gate_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N:0]   vec_count,
  output state_t       state
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic         first_fail_vld,
  output logic [N-1:0] first_fail_vec
`endif
);

  // Handshake: start is a one-cycle request taken only while busy is low;
  // done/pass/counts are registered, valid together once done is high, and
  // held until the next accepted start or rst.

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [N-1:0]   VEC_LAST    = '1;

  logic [SCW-1:0] settle_cnt;
  logic [2:0]     op_q;
  logic           exp_bit;
  logic           mismatch;
  logic [N:0]     err_next;

  gate_ref_model #(.N(N)) u_ref (
    .op (op_q),
    .vec(gate_in),
    .y  (exp_bit)
  );

  // Case-equality so an unknown DUT output is scored as a failure.
  assign mismatch = (gate_out !== exp_bit);
  assign err_next = err_count + {{N{1'b0}}, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gate_in    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      vec_count  <= '0;
      settle_cnt <= '0;
      op_q       <= OP_AND;
`ifdef FIRST_FAIL_CAPTURE_EN
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q       <= op;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
            gate_in    <= '0;
            settle_cnt <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
`endif
            if (op_legal(op)) begin
              busy  <= 1'b1;
              state <= DRIVE;
            end else begin
              // Nothing meaningful to sweep: report a failed, empty sweep.
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SCW'(1);
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          vec_count <= vec_count + (N+1)'(1);
`ifdef FIRST_FAIL_CAPTURE_EN
          if (mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= gate_in;
          end
`endif
          if (gate_in == VEC_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= DONE;
          end else begin
            gate_in    <= gate_in + N'(1);
            settle_cnt <= '0;
            state      <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_engine.sv
// Bench for gate_sweep_engine: table vectors, corner sequences and random sweeps vs a truth-table model.
module tb_gate_sweep_engine;
  import gate_sweep_pkg::*;

  localparam int NA = 2;
  localparam int SA = 2;
  localparam int NB = 4;
  localparam int SB = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- instance A (N=2, SETTLE=2) ----------------
  logic          start_a;
  logic [2:0]    op_a;
  logic [NA-1:0] gate_in_a;
  logic          gate_out_a;
  logic          busy_a, done_a, pass_a;
  logic [NA:0]   err_a, vec_a;
  state_t        state_a;
  int            kind_a, fault_vec_a;
  logic          fault_en_a, fault_val_a;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic          ffv_a;
  logic [NA-1:0] ffvec_a;
`endif

  gate_sweep_engine #(.N(NA), .SETTLE(SA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .op(op_a),
    .gate_in(gate_in_a), .gate_out(gate_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .vec_count(vec_a), .state(state_a)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .first_fail_vld(ffv_a), .first_fail_vec(ffvec_a)
`endif
  );

  // ---------------- instance B (N=4, SETTLE=1) ----------------
  logic          start_b;
  logic [2:0]    op_b;
  logic [NB-1:0] gate_in_b;
  logic          gate_out_b;
  logic          busy_b, done_b, pass_b;
  logic [NB:0]   err_b, vec_b;
  state_t        state_b;
  int            kind_b, fault_vec_b;
  logic          fault_en_b, fault_val_b;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic          ffv_b;
  logic [NB-1:0] ffvec_b;
`endif

  gate_sweep_engine #(.N(NB), .SETTLE(SB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .op(op_b),
    .gate_in(gate_in_b), .gate_out(gate_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .vec_count(vec_b), .state(state_b)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .first_fail_vld(ffv_b), .first_fail_vec(ffvec_b)
`endif
  );

  // ---------------- truth-table model (plain arithmetic) ----------------
  function automatic logic model_fn(input int op, input int v, input int n);
    int all_ones;
    all_ones = (1 << n) - 1;
    case (op)
      0: return (v == all_ones);
      1: return (v != 0);
      2: return (v != all_ones);
      3: return (v == 0);
      4: return ($countones(v) % 2) == 1;
      5: return ($countones(v) % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Gate DUT models, with one optional forced output value at one vector.
  always_comb begin
    gate_out_a = model_fn(kind_a, int'(gate_in_a), NA);
    if (fault_en_a && int'(gate_in_a) == fault_vec_a) gate_out_a = fault_val_a;
  end
  always_comb begin
    gate_out_b = model_fn(kind_b, int'(gate_in_b), NB);
    if (fault_en_b && int'(gate_in_b) == fault_vec_b) gate_out_b = fault_val_b;
  end

  task automatic expect_sweep(input int n, input int kind, input int op,
                              input logic fen, input int fvec, input logic fval,
                              output logic e_pass, output int e_err, output int e_vec,
                              output logic e_ffv, output int e_ffvec);
    logic d;
    e_err = 0; e_vec = 0; e_ffv = 1'b0; e_ffvec = 0;
    if (op > 5) begin
      e_pass = 1'b0;
      return;
    end
    for (int v = 0; v < (1 << n); v++) begin
      d = (fen && v == fvec) ? fval : model_fn(kind, v, n);
      if (d != model_fn(op, v, n)) begin
        if (!e_ffv) begin e_ffv = 1'b1; e_ffvec = v; end
        e_err++;
      end
    end
    e_vec  = 1 << n;
    e_pass = (e_err == 0);
  endtask

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Edge 0 is the edge that samples start; edges counts edges after it until done.
  task automatic sweep_a(input logic [2:0] op, input bit noise, output int edges);
    int   limit;
    logic legal;
    limit = 4 * (1 << NA) * (SA + 1) + 10;
    legal = (op <= 3'd5);
    @(negedge clk); op_a = op; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; edges = 0;
    check("a_busy_after_start", busy_a, legal);
    while (!done_a && edges < limit) begin
      @(negedge clk);
      if (noise) start_a = busy_a ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      start_a = 1'b0;
      edges++;
      if (legal && edges < (1 << NA) * (SA + 1)) begin
        check("a_gate_in_seq", gate_in_a, edges / (SA + 1));
        check("a_vec_progress", vec_a, edges / (SA + 1));
      end
    end
    start_a = 1'b0;
    if (edges >= limit) check("a_done_timeout", done_a, 1);
  endtask

  task automatic sweep_b(input logic [2:0] op, output int edges);
    int limit;
    limit = 4 * (1 << NB) * (SB + 1) + 10;
    @(negedge clk); op_b = op; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0; edges = 0;
    while (!done_b && edges < limit) begin
      @(posedge clk); #1;
      edges++;
    end
    if (edges >= limit) check("b_done_timeout", done_b, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    int         kind;
    logic       fen;
    int         fvec;
    logic       fval;
    logic [2:0] op;
    int         edges;
    logic       e_pass;
    int         e_err;
    int         e_vec;
    logic       e_ffv;
    int         e_ffvec;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int   edges;
    logic e_pass, e_ffv;
    int   e_err, e_vec, e_ffvec;
    logic [2:0] rop;

    tbl[0] = '{"nand_ok",      2, 1'b0, 0, 1'b0, 3'd2, 12, 1'b1, 0, 4, 1'b0, 0};
    tbl[1] = '{"nand_vs_and",  2, 1'b0, 0, 1'b0, 3'd0, 12, 1'b0, 4, 4, 1'b1, 0};
    // XOR with its vector-3 output forced high, disagreeing only there.
    tbl[2] = '{"xor_fault3",   4, 1'b1, 3, 1'b1, 3'd4, 12, 1'b0, 1, 4, 1'b1, 3};
    tbl[3] = '{"xnor_ok",      5, 1'b0, 0, 1'b0, 3'd5, 12, 1'b1, 0, 4, 1'b0, 0};
    tbl[4] = '{"or_vs_nor",    1, 1'b0, 0, 1'b0, 3'd3, 12, 1'b0, 4, 4, 1'b1, 0};
    tbl[5] = '{"rsvd_op6",     0, 1'b0, 0, 1'b0, 3'd6, 0,  1'b0, 0, 0, 1'b0, 0};
    tbl[6] = '{"and_vs_or",    0, 1'b0, 0, 1'b0, 3'd1, 12, 1'b0, 2, 4, 1'b1, 1};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; op_a = '0; op_b = '0;
    kind_a = 2; fault_en_a = 1'b0; fault_vec_a = 0; fault_val_a = 1'b0;
    kind_b = 3; fault_en_b = 1'b0; fault_vec_b = 0; fault_val_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_gate_in", gate_in_a, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_a_pass", pass_a, 0);
    check("rst_a_err", err_a, 0);
    check("rst_a_vec", vec_a, 0);
    check("rst_a_state", state_a, IDLE);
    check("rst_b_done", done_b, 0);
    @(negedge clk); rst = 1'b0;

    // Table-driven sweeps on instance A.
    foreach (tbl[i]) begin
      kind_a = tbl[i].kind; fault_en_a = tbl[i].fen;
      fault_vec_a = tbl[i].fvec; fault_val_a = tbl[i].fval;
      sweep_a(tbl[i].op, 1'b0, edges);
      check({tbl[i].name, "_done_edge"}, edges, tbl[i].edges);
      check({tbl[i].name, "_done"}, done_a, 1);
      check({tbl[i].name, "_busy"}, busy_a, 0);
      check({tbl[i].name, "_pass"}, pass_a, tbl[i].e_pass);
      check({tbl[i].name, "_err"}, err_a, tbl[i].e_err);
      check({tbl[i].name, "_vec"}, vec_a, tbl[i].e_vec);
      check({tbl[i].name, "_gate_in_hold"}, gate_in_a, (tbl[i].op <= 3'd5) ? 3 : 0);
`ifdef FIRST_FAIL_CAPTURE_EN
      check({tbl[i].name, "_ff_vld"}, ffv_a, tbl[i].e_ffv);
      if (tbl[i].e_ffv) check({tbl[i].name, "_ff_vec"}, ffvec_a, tbl[i].e_ffvec);
`endif
    end
    fault_en_a = 1'b0;

    // Reset asserted on edge 5 of a sweep aborts it without done.
    kind_a = 2;
    @(negedge clk); op_a = 3'd2; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_state", state_a, IDLE);
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_gate_in", gate_in_a, 0);
    check("midrst_vec", vec_a, 0);
    @(negedge clk); rst = 1'b0;
    // Clean restart while start is randomly re-pulsed during busy.
    sweep_a(3'd2, 1'b1, edges);
    check("restart_done_edge", edges, 12);
    check("restart_pass", pass_a, 1);
    check("restart_err", err_a, 0);
    check("restart_vec", vec_a, 4);

    // Reserved op from DONE: immediate failed, empty sweep.
    sweep_a(3'd7, 1'b0, edges);
    check("rsvd7_done_edge", edges, 0);
    check("rsvd7_done", done_a, 1);
    check("rsvd7_pass", pass_a, 0);
    check("rsvd7_vec", vec_a, 0);

    // Random sweeps on A against the model.
    for (int it = 0; it < 14; it++) begin
      kind_a = $urandom_range(0, 5);
      rop = 3'($urandom_range(0, 7));
      fault_en_a = 1'($urandom_range(0, 1));
      fault_vec_a = $urandom_range(0, 3);
      fault_val_a = 1'($urandom_range(0, 1));
      expect_sweep(NA, kind_a, int'(rop), fault_en_a, fault_vec_a, fault_val_a,
                   e_pass, e_err, e_vec, e_ffv, e_ffvec);
      sweep_a(rop, 1'($urandom_range(0, 1)), edges);
      check("rnd_a_done_edge", edges, (rop <= 3'd5) ? 12 : 0);
      check("rnd_a_pass", pass_a, e_pass);
      check("rnd_a_err", err_a, e_err);
      check("rnd_a_vec", vec_a, e_vec);
`ifdef FIRST_FAIL_CAPTURE_EN
      check("rnd_a_ff_vld", ffv_a, e_ffv);
      if (e_ffv) check("rnd_a_ff_vec", ffvec_a, e_ffvec);
`endif
    end

    // Instance B: N=4, SETTLE=1, NOR against NOR.
    kind_b = 3;
    sweep_b(3'd3, edges);
    check("b_nor_done_edge", edges, 32);
    check("b_nor_vec", vec_b, 16);
    check("b_nor_err", err_b, 0);
    check("b_nor_pass", pass_b, 1);
    check("b_nor_gate_in_hold", gate_in_b, 15);
    // New start from DONE clears done and restarts.
    @(negedge clk); op_b = 3'd3; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    check("b_restart_done", done_b, 0);
    check("b_restart_busy", busy_b, 1);
    check("b_restart_vec", vec_b, 0);
    edges = 0;
    while (!done_b && edges < 100) begin @(posedge clk); #1; edges++; end
    check("b_restart_done_edge", edges, 32);

    for (int it = 0; it < 6; it++) begin
      kind_b = $urandom_range(0, 5);
      rop = 3'($urandom_range(0, 7));
      fault_en_b = 1'($urandom_range(0, 1));
      fault_vec_b = $urandom_range(0, 15);
      fault_val_b = 1'($urandom_range(0, 1));
      expect_sweep(NB, kind_b, int'(rop), fault_en_b, fault_vec_b, fault_val_b,
                   e_pass, e_err, e_vec, e_ffv, e_ffvec);
      sweep_b(rop, edges);
      check("rnd_b_done_edge", edges, (rop <= 3'd5) ? 32 : 0);
      check("rnd_b_pass", pass_b, e_pass);
      check("rnd_b_err", err_b, e_err);
      check("rnd_b_vec", vec_b, e_vec);
`ifdef FIRST_FAIL_CAPTURE_EN
      check("rnd_b_ff_vld", ffv_b, e_ffv);
      if (e_ffv) check("rnd_b_ff_vec", ffvec_b, e_ffvec);
`endif
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
